// File: rtl/fpga_pll_rst_ctrl_if.sv
// Signal bundle between the PLL reset/lock sequencer and the two managed PLLs
// plus their clock domains. The controller uses the slave view.
interface fpga_pll_rst_ctrl_if;
  logic [1:0] pll_locked_in;
  logic [1:0] pll_areset;
  logic [1:0] dom_rst_n;
  logic [1:0] pll_fail;
  logic       all_locked;

  modport master (
    output pll_locked_in,
    input  pll_areset,
    input  dom_rst_n,
    input  pll_fail,
    input  all_locked
  );

  modport slave (
    input  pll_locked_in,
    output pll_areset,
    output dom_rst_n,
    output pll_fail,
    output all_locked
  );
endinterface

// File: rtl/fpga_pll_rst_ctrl.sv
// PLL reset/lock sequencer: two independent channels (system, audio) with lock filtering.
// Optional FPGA_PLL_RETRY_EN: timeout retries with re-reset and a forced re-reset on lock loss.
module fpga_pll_rst_ctrl #(
  parameter int AREST_CYCLES = 4,
  parameter int LOCK_FILTER  = 256,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RETRY    = 3
) (
  input logic                fclk,
  input logic                reset_n,
  fpga_pll_rst_ctrl_if.slave pll
);

  localparam logic [2:0] ST_ARST = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_FILT = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_FAIL = 3'd4;

  localparam logic [15:0] AREST_LAST   = 16'(AREST_CYCLES - 1);
  localparam logic [15:0] FILTER_LAST  = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
`ifdef FPGA_PLL_RETRY_EN
  localparam logic [3:0]  RTY_MAX      = 4'(MAX_RETRY);
`endif

  // Lock flags come straight from the PLLs, asynchronous to fclk.
  logic [1:0] sync_q1;
  logic [1:0] lock_s;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      lock_s  <= '0;
    end else begin
      sync_q1 <= pll.pll_locked_in;
      lock_s  <= sync_q1;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        areset_q, dom_q, fail_q;
`ifdef FPGA_PLL_RETRY_EN
    logic [3:0]  rty_q, rty_d;
`endif

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef FPGA_PLL_RETRY_EN
      rty_d   = rty_q;
`endif
      case (state_q)
        ST_ARST: begin
          if (cnt_q == AREST_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_WAIT: begin
          // A lock arriving on the timeout cycle takes priority over the timeout.
          if (lock_s[ch]) begin
            state_d = ST_FILT;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
`ifdef FPGA_PLL_RETRY_EN
            if (rty_q == RTY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              rty_d   = rty_q + 4'd1;
              state_d = ST_ARST;
              cnt_d   = '0;
            end
`else
            state_d = ST_FAIL;
`endif
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_FILT: begin
          // A dropout restarts both the filter and the timeout window.
          if (!lock_s[ch]) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == FILTER_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
`ifdef FPGA_PLL_RETRY_EN
            rty_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_RUN: begin
          if (!lock_s[ch]) begin
`ifdef FPGA_PLL_RETRY_EN
            state_d = ST_ARST;
`else
            state_d = ST_WAIT;
`endif
            cnt_d = '0;
          end
        end
        ST_FAIL: ;
        default: begin
          state_d = ST_ARST;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge fclk or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= ST_ARST;
        cnt_q    <= '0;
        areset_q <= 1'b1;
        dom_q    <= 1'b0;
        fail_q   <= 1'b0;
`ifdef FPGA_PLL_RETRY_EN
        rty_q    <= '0;
`endif
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        areset_q <= (state_d == ST_ARST) || (state_d == ST_FAIL);
        dom_q    <= (state_d == ST_RUN);
        fail_q   <= (state_d == ST_FAIL);
`ifdef FPGA_PLL_RETRY_EN
        rty_q    <= rty_d;
`endif
      end
    end
  end

  logic all_locked_q;

  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) all_locked_q <= 1'b0;
    else          all_locked_q <= (g_ch[0].state_d == ST_RUN) && (g_ch[1].state_d == ST_RUN);
  end

  assign pll.pll_areset = {g_ch[1].areset_q, g_ch[0].areset_q};
  assign pll.dom_rst_n  = {g_ch[1].dom_q,    g_ch[0].dom_q};
  assign pll.pll_fail   = {g_ch[1].fail_q,   g_ch[0].fail_q};
  assign pll.all_locked = all_locked_q;

endmodule

// File: tb/tb_fpga_pll_rst_ctrl.sv
// Scoreboard bench for fpga_pll_rst_ctrl: every output change is matched, in order,
// against hand-computed {cycle, output vector} events queued by the stimulus.
module tb_fpga_pll_rst_ctrl;
  localparam int AREST_CYCLES = 4;
  localparam int LOCK_FILTER  = 8;
  localparam int LOCK_TIMEOUT = 100;
  localparam int MAX_RETRY    = 2;

  // Output vector layout: {pll_areset[1:0], dom_rst_n[1:0], pll_fail[1:0], all_locked}
  localparam logic [6:0] V_RST  = 7'b11_00_00_0;
  localparam logic [6:0] V_ZERO = 7'b00_00_00_0;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
    string      tag;
  } exp_t;

  logic fclk    = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   rel     = 0;
  int   checks  = 0;
  int   failures = 0;
  exp_t sb[$];

  fpga_pll_rst_ctrl_if pll_if ();

  fpga_pll_rst_ctrl #(
    .AREST_CYCLES(AREST_CYCLES),
    .LOCK_FILTER (LOCK_FILTER),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .fclk   (fclk),
    .reset_n(reset_n),
    .pll    (pll_if)
  );

  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc++;

  function automatic logic [6:0] mk(logic [1:0] ar, logic [1:0] dom, logic [1:0] fl, logic al);
    return {ar, dom, fl, al};
  endfunction

  task automatic expect_at(input int c, input logic [6:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance to just after rising edge number c.
  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(posedge fclk);
      #2;
    end
  endtask

  task automatic assert_reset(input string tag);
    reset_n = 1'b0;
    expect_at(cyc, V_RST, tag);
  endtask

  task automatic release_reset();
    to_cycle(cyc + 2);
    reset_n = 1'b1;
    rel     = cyc;
  endtask

  // Monitor: each observed change of the output vector consumes one expected event.
  logic [6:0] prev_vec = 'x;
  logic [6:0] cur_vec;
  exp_t       head;

  always @(negedge fclk) begin
    cur_vec = {pll_if.pll_areset, pll_if.dom_rst_n, pll_if.pll_fail, pll_if.all_locked};
    if (cur_vec !== prev_vec) begin
      prev_vec = cur_vec;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cycle=%0d got=%b expected no change", cyc, cur_vec);
      end else begin
        head = sb.pop_front();
        if (cur_vec !== head.vec) begin
          failures++;
          $display("FAIL %s value got=%b expected=%b (cycle %0d)", head.tag, cur_vec, head.vec, cyc);
        end
        checks++;
        if (cyc != head.cyc) begin
          failures++;
          $display("FAIL %s cycle got=%0d expected=%0d", head.tag, cyc, head.cyc);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog cycle=%0d expected run to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    pll_if.pll_locked_in = 2'b00;
    expect_at(1, V_RST, "reset_state");

    // Basic bring-up: both locks raised 10 cycles after release.
    release_reset();
    expect_at(rel + 4,  V_ZERO, "t1_areset_fall");
    expect_at(rel + 21, mk(2'b00, 2'b11, 2'b00, 1'b1), "t1_both_run");
    to_cycle(rel + 10);
    pll_if.pll_locked_in = 2'b11;
    to_cycle(rel + 30);

    // Glitch on lock0 while filtering; lock1 steady from release.
    assert_reset("t2_reset");
    pll_if.pll_locked_in = 2'b10;
    release_reset();
    expect_at(rel + 4,  V_ZERO, "t2_areset_fall");
    expect_at(rel + 13, mk(2'b00, 2'b10, 2'b00, 1'b0), "t2_ch1_run");
    expect_at(rel + 27, mk(2'b00, 2'b11, 2'b00, 1'b1), "t2_ch0_run_after_glitch");
    to_cycle(rel + 10);
    pll_if.pll_locked_in = 2'b11;
    to_cycle(rel + 15);
    pll_if.pll_locked_in = 2'b10;
    to_cycle(rel + 16);
    pll_if.pll_locked_in = 2'b11;

    // Lock loss on ch0 in RUN, lock restored 20 cycles later.
    t = rel + 40;
`ifdef FPGA_PLL_RETRY_EN
    expect_at(t + 3, mk(2'b01, 2'b10, 2'b00, 1'b0), "t3_loss_rereset");
    expect_at(t + 7, mk(2'b00, 2'b10, 2'b00, 1'b0), "t3_rereset_end");
`else
    expect_at(t + 3, mk(2'b00, 2'b10, 2'b00, 1'b0), "t3_loss_dom_fall");
`endif
    expect_at(t + 31, mk(2'b00, 2'b11, 2'b00, 1'b1), "t3_relock_run");
    to_cycle(t);
    pll_if.pll_locked_in = 2'b10;
    to_cycle(t + 20);
    pll_if.pll_locked_in = 2'b11;
    to_cycle(t + 40);

    // ch1 never locks: timeout (and retries when enabled) ending in FAIL.
    assert_reset("t4_reset");
    pll_if.pll_locked_in = 2'b01;
    release_reset();
    expect_at(rel + 4,  V_ZERO, "t4_areset_fall");
    expect_at(rel + 13, mk(2'b00, 2'b01, 2'b00, 1'b0), "t4_ch0_run");
`ifdef FPGA_PLL_RETRY_EN
    expect_at(rel + 104, mk(2'b10, 2'b01, 2'b00, 1'b0), "t4_retry1_pulse");
    expect_at(rel + 108, mk(2'b00, 2'b01, 2'b00, 1'b0), "t4_retry1_end");
    expect_at(rel + 208, mk(2'b10, 2'b01, 2'b00, 1'b0), "t4_retry2_pulse");
    expect_at(rel + 212, mk(2'b00, 2'b01, 2'b00, 1'b0), "t4_retry2_end");
    expect_at(rel + 312, mk(2'b10, 2'b01, 2'b10, 1'b0), "t4_ch1_fail");
`else
    expect_at(rel + 104, mk(2'b10, 2'b01, 2'b10, 1'b0), "t4_ch1_fail");
`endif
    to_cycle(rel + 330);

    // Reset out of FAIL, then ch1 locks exactly on its timeout cycle.
    assert_reset("t5_reset_from_fail");
    pll_if.pll_locked_in = 2'b01;
    release_reset();
    expect_at(rel + 4,   V_ZERO, "t5_areset_fall");
    expect_at(rel + 13,  mk(2'b00, 2'b01, 2'b00, 1'b0), "t5_ch0_run");
    expect_at(rel + 112, mk(2'b00, 2'b11, 2'b00, 1'b1), "t5_lock_on_timeout_run");
    to_cycle(rel + 101);
    pll_if.pll_locked_in = 2'b11;
    to_cycle(rel + 125);

    // Reset while both channels are in FILT, then full bring-up.
    assert_reset("t6_reset");
    release_reset();
    expect_at(rel + 4, V_ZERO, "t6_areset_fall");
    to_cycle(rel + 8);
    assert_reset("t6_reset_in_filt");
    release_reset();
    expect_at(rel + 4,  V_ZERO, "t6_areset_fall2");
    expect_at(rel + 13, mk(2'b00, 2'b11, 2'b00, 1'b1), "t6_both_run");
    to_cycle(rel + 25);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0 next=%s", sb.size(), sb[0].tag);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpga_pll_rst_ctrl.md
# fpga_pll_rst_ctrl

PLL reset and lock sequencer for the V2M-MPS2 FPGA clock subsystem. It drives `areset` of the system PLL (channel 0) and the audio PLL (channel 1), and filters their `locked` outputs. It releases one domain reset per PLL only after that PLL has held lock for a programmable stable interval. It retries PLLs that fail to lock and reports hard failures.

## Interface
Parameters:
- `AREST_CYCLES`, 4: width of each `pll_areset` pulse, in `fclk` cycles (1..65535).
- `LOCK_FILTER`, 256: consecutive synchronized-locked samples required before a domain reset is released (1..65535).
- `LOCK_TIMEOUT`, 50000: cycles spent in WAIT without lock before a timeout (1..65535).
- `MAX_RETRY`, 3: timeouts tolerated per channel before FAIL (0..15).

Ports:
- `fclk` in 1: single clock. Free-running and not sourced from either managed PLL.
- `reset_n` in 1: reset, asynchronous and active-low.
- `pll_locked_in` in 2: raw PLL lock flags, asynchronous. [0]=system, [1]=audio.
- `pll_areset` out 2: PLL reset requests, active-high, registered.
- `dom_rst_n` out 2: domain resets, active-low, registered. [0]=system domain, [1]=audio domain.
- `pll_fail` out 2: sticky channel failure flags.
- `all_locked` out 1: high when both channels are in RUN.

## Operation
- Each `pll_locked_in[i]` passes through its own 2-flop synchronizer to give `lock_s[i]`.
- Two identical, independent per-channel FSMs. Each has a 16-bit counter `cnt` and a 4-bit retry counter `rty`.
- ARST: `pll_areset`=1.
  - `cnt` increments each cycle.
  - When `cnt`==AREST_CYCLES-1, go to WAIT with `cnt`=0.
- WAIT: `pll_areset`=0.
  - If `lock_s` is high, go to FILT with `cnt`=0.
  - Else if `cnt`==LOCK_TIMEOUT-1, a timeout occurs (see Configuration).
  - Else `cnt` increments.
- FILT: `pll_areset`=0.
  - If `lock_s` is low, go to WAIT with `cnt`=0. The timeout window restarts.
  - Else if `cnt`==LOCK_FILTER-1, go to RUN and clear `rty`.
  - Else `cnt` increments.
- RUN: `dom_rst_n`=1. If `lock_s` drops, handle lock loss (see Configuration).
- FAIL: `pll_areset`=1, `dom_rst_n`=0, `pll_fail`=1. Exit only via `reset_n`.
- All outputs are Moore outputs, registered from the next state.
- `dom_rst_n[i]` is high only in RUN.
- `all_locked` = RUN(ch0) & RUN(ch1).
- Simultaneous events:
  - WAIT with `lock_s`=1 on the timeout cycle: lock wins and the FSM goes to FILT.
  - FILT with `lock_s` low on the cycle `cnt` reaches the limit: the drop wins and the FSM goes to WAIT.
- The channels never interact. A failure in the audio channel does not affect `dom_rst_n[0]`.

## Timing
- Reset values:
  - `pll_areset`=2'b11, `dom_rst_n`=2'b00, `pll_fail`=2'b00, `all_locked`=0.
  - FSMs in ARST, `cnt`=0, `rty`=0, synchronizers cleared.
- `reset_n` assertion mid-operation returns everything to reset values immediately (asynchronously).
- `pll_areset` falls on the AREST_CYCLES-th rising edge after `reset_n` deasserts, so the pulse lasts exactly AREST_CYCLES cycles.
- Lock-to-release latency: if `pll_locked_in` is first sampled high at edge E0 and stays high, `dom_rst_n` rises at edge E0+LOCK_FILTER+2.
- Lock-loss latency: if `pll_locked_in` is sampled low at edge E0, `dom_rst_n` falls at edge E0+2.
- Timeout: WAIT is exited LOCK_TIMEOUT cycles after it was entered.
- Consumer domains resynchronize `dom_rst_n` deassertion locally. This block does not do that.

## Configuration
- Macro `FPGA_PLL_RETRY_EN`.
- Defined:
  - WAIT timeout with `rty`<MAX_RETRY: `rty` increments and the FSM goes to ARST (a new areset pulse).
  - WAIT timeout with `rty`==MAX_RETRY: go to FAIL.
  - Lock loss in RUN: go to ARST and force a re-reset. `rty` is unchanged.
- Not defined:
  - WAIT timeout goes directly to FAIL. `rty` is not implemented.
  - Lock loss in RUN goes to WAIT with `cnt`=0 and does not pulse `pll_areset`; the PLL's own self-reset-on-loss-of-lock handles recovery.

## Test plan
Bench parameters: AREST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=100, MAX_RETRY=2.
- Release `reset_n`, then raise both locks 10 cycles later and hold them. Expect `pll_areset` low at edge 4, `dom_rst_n`=2'b11 10 edges after lock is first sampled, and `all_locked`=1.
- Glitch: hold lock0 high for 5 cycles, drop it for 1 cycle, then hold it high. Expect FILT to restart and `dom_rst_n[0]` to rise 10 edges after the second rising edge.
- Hold lock1 low with the macro defined. Expect 3 `pll_areset[1]` pulses and `pll_fail[1]`=1 after ~3×104 cycles, while `dom_rst_n[0]` is unaffected. With the macro undefined, expect FAIL after 100 cycles of WAIT and no retry pulse.
- Drop lock0 in RUN. Expect `dom_rst_n[0]` low 2 edges later. With the macro defined, expect a 4-cycle `pll_areset[0]` pulse next; with it undefined, expect no pulse.
- Lock rises exactly on the timeout cycle. Expect FILT, no retry, and `rty` unchanged.
- Assert `reset_n` while a channel is in FILT and while a channel is in FAIL. Expect immediate reset values, with `pll_fail` cleared.
